// File: rtl/accel_mem_arbiter_rr.sv
// accel_mem_arbiter_rr
//   Registered N-port arbiter that shares one single-port RAM between the CPU
//   (index 0) and the accelerator masters (FFT, crypto, DMA, ...).
//   Requests use a valid/ready handshake. Arbitration is either fixed priority
//   (lowest index wins) or round-robin with a per-requester burst limit.
//   The granted command is registered onto the RAM port one cycle after the
//   handshake. Read data is routed back to the issuing requester exactly
//   RAM_LAT cycles after the registered RAM read command.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   rr_mode         0 = fixed priority, 1 = round-robin
//   req_valid       per-requester request valid
//   req_write       per-requester write flag
//   req_addr        flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata       flattened write data, requester i at [i*DATA_W +: DATA_W]
//   req_ready       one-hot combinational grant/accept
//   rsp_valid       one-hot read-response pulse
//   rsp_rdata       read data shared by all requesters, qualified by rsp_valid
//   ram_valid/ram_write/ram_addr/ram_wdata   registered RAM command
//   ram_rdata       RAM read data
//   grant_cnt       per-requester saturating 16-bit transfer counters
//                   (only when ARB_PERF_EN is defined)
//
// Build option
//   ARB_PERF_EN     adds grant_cnt and its counters.

module accel_mem_arbiter_rr #(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 19,
    parameter int RAM_LAT   = 1,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rr_mode,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      ram_valid,
    output logic                      ram_write,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_wdata,
    input  logic [DATA_W-1:0]         ram_rdata
`ifdef ARB_PERF_EN
    ,
    output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Arbitration state
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [3:0]       burst_q, burst_d;
    logic             last_vld_q, last_vld_d;
    logic [IDX_W-1:0] last_idx_q, last_idx_d;

    // RAM command stage
    logic              ram_valid_q, ram_valid_d;
    logic              ram_write_q, ram_write_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    // Read-response tracking: one-hot requester ID per pipe stage
    logic [RAM_LAT-1:0][NUM_REQ-1:0] pipe_q, pipe_d;
    logic [NUM_REQ-1:0]              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]               rsp_rdata_q, rsp_rdata_d;

    // Combinational arbitration results
    logic               fx_found, rr_found;
    logic [IDX_W-1:0]   fx_idx, rr_idx, scan_idx;
    logic               grant_vld;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic               xfer;
    logic               sel_write;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    always_comb begin
        // Fixed priority: lowest valid index.
        fx_found = 1'b0;
        fx_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!fx_found && req_valid[i]) begin
                fx_found = 1'b1;
                fx_idx   = IDX_W'(i);
            end
        end

        // Round-robin: first valid index starting at the pointer, wrapping.
        rr_found = 1'b0;
        rr_idx   = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
            if (!rr_found && req_valid[scan_idx]) begin
                rr_found = 1'b1;
                rr_idx   = scan_idx;
            end
        end

        grant_vld  = 1'b0;
        grant_idx  = '0;
        ptr_d      = ptr_q;
        burst_d    = burst_q;
        last_vld_d = last_vld_q;
        last_idx_d = last_idx_q;

        if (!rr_mode) begin
            // Fixed mode also forgets the last grantee so a later switch to
            // round-robin starts a fresh search from index 0.
            grant_vld  = fx_found;
            grant_idx  = fx_idx;
            ptr_d      = '0;
            burst_d    = '0;
            last_vld_d = 1'b0;
        end else if (last_vld_q && req_valid[last_idx_q] && (burst_q < 4'(MAX_BURST))) begin
            grant_vld = 1'b1;
            grant_idx = last_idx_q;
            burst_d   = burst_q + 4'd1;
        end else if (rr_found) begin
            // A lone requester is found again here, so the burst limit
            // never idles the bus.
            grant_vld  = 1'b1;
            grant_idx  = rr_idx;
            burst_d    = 4'd1;
            ptr_d      = (rr_idx == IDX_W'(NUM_REQ - 1)) ? '0 : rr_idx + IDX_W'(1);
            last_vld_d = 1'b1;
            last_idx_d = rr_idx;
        end

        grant_oh = '0;
        if (grant_vld) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    assign req_ready = grant_oh & {NUM_REQ{rst_n}};
    assign xfer      = |req_ready;

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end

        ram_valid_d = xfer;
        ram_write_d = xfer ? sel_write : ram_write_q;
        ram_addr_d  = xfer ? sel_addr  : ram_addr_q;
        ram_wdata_d = xfer ? sel_wdata : ram_wdata_q;

        // Stage 0 is loaded on the same edge as ram_valid; the response is
        // registered from the last stage, landing RAM_LAT cycles after it.
        pipe_d    = '0;
        pipe_d[0] = (xfer && !sel_write) ? req_ready : '0;
        for (int unsigned k = 1; k < RAM_LAT; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end

        rsp_valid_d = pipe_q[RAM_LAT-1];
        rsp_rdata_d = (|pipe_q[RAM_LAT-1]) ? ram_rdata : rsp_rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            burst_q     <= '0;
            last_vld_q  <= 1'b0;
            last_idx_q  <= '0;
            ram_valid_q <= 1'b0;
            ram_write_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            pipe_q      <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            burst_q     <= burst_d;
            last_vld_q  <= last_vld_d;
            last_idx_q  <= last_idx_d;
            ram_valid_q <= ram_valid_d;
            ram_write_q <= ram_write_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            pipe_q      <= pipe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign ram_valid = ram_valid_q;
    assign ram_write = ram_write_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

`ifdef ARB_PERF_EN
    logic [NUM_REQ*16-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] && (cnt_q[i*16 +: 16] != 16'hFFFF)) begin
                cnt_d[i*16 +: 16] = cnt_q[i*16 +: 16] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_accel_mem_arbiter_rr.sv
module tb_accel_mem_arbiter_rr;

    localparam int NUM_REQ   = 3;
    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 19;
    localparam int RAM_LAT   = 2;
    localparam int MAX_BURST = 2;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      rr_mode;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      ram_valid;
    logic                      ram_write;
    logic [ADDR_W-1:0]         ram_addr;
    logic [DATA_W-1:0]         ram_wdata;
    logic [DATA_W-1:0]         ram_rdata;
`ifdef ARB_PERF_EN
    logic [NUM_REQ*16-1:0]     grant_cnt;
`endif

    logic [ADDR_W-1:0] a [NUM_REQ];
    logic [DATA_W-1:0] d [NUM_REQ];

    assign req_addr  = {a[2], a[1], a[0]};
    assign req_wdata = {d[2], d[1], d[0]};

    accel_mem_arbiter_rr #(
        .NUM_REQ  (NUM_REQ),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RAM_LAT  (RAM_LAT),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rr_mode  (rr_mode),
        .req_valid(req_valid),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .ram_valid(ram_valid),
        .ram_write(ram_write),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
`ifdef ARB_PERF_EN
        ,
        .grant_cnt(grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;
    int exp_cnt [NUM_REQ];

    function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] ad);
        if (ad == 19'h5) return 19'h1ABCD;
        return ad ^ 19'h5A5A5;
    endfunction

    // RAM model: read data valid the cycle after the RAM samples the command,
    // so the arbiter captures it RAM_LAT (=2) cycles after ram_valid.
    always @(posedge clk) begin
        if (ram_valid && !ram_write) ram_rdata <= data_of(ram_addr);
    end

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                due;
    } cmd_t;

    typedef struct {
        logic [NUM_REQ-1:0] id;
        logic [DATA_W-1:0]  data;
        int                 due;
    } rsp_t;

    cmd_t cmd_q [$];
    rsp_t rsp_q [$];

    // Scoreboard push for a transfer expected from requester i in this cycle.
    task automatic push_xfer(input int i);
        cmd_t c;
        rsp_t r;
        c.wr    = req_write[i];
        c.addr  = a[i];
        c.wdata = d[i];
        c.due   = cyc + 1;
        cmd_q.push_back(c);
        if (!req_write[i]) begin
            r.id   = 3'(1 << i);
            r.data = data_of(a[i]);
            r.due  = cyc + 1 + RAM_LAT;
            rsp_q.push_back(r);
        end
        exp_cnt[i]++;
    endtask

    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] wd);
        req_valid[i] = v;
        req_write[i] = w;
        a[i]         = ad;
        d[i]         = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard pops: RAM command and read response checked every cycle.
    always @(negedge clk) begin
        cmd_t c;
        rsp_t r;
        checks++;
        if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
            c = cmd_q.pop_front();
            if (ram_valid !== 1'b1 || ram_write !== c.wr || ram_addr !== c.addr || ram_wdata !== c.wdata) begin
                $display("FAIL ram_cmd cyc=%0d: got v=%b w=%b a=%0h d=%0h expected v=1 w=%b a=%0h d=%0h",
                         cyc, ram_valid, ram_write, ram_addr, ram_wdata, c.wr, c.addr, c.wdata);
                fails++;
            end
        end else if (ram_valid !== 1'b0) begin
            $display("FAIL ram_idle cyc=%0d: got ram_valid=%b expected 0", cyc, ram_valid);
            fails++;
        end
        checks++;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            r = rsp_q.pop_front();
            if (rsp_valid !== r.id || rsp_rdata !== r.data) begin
                $display("FAIL rsp cyc=%0d: got id=%b data=%0h expected id=%b data=%0h",
                         cyc, rsp_valid, rsp_rdata, r.id, r.data);
                fails++;
            end
        end else if (rsp_valid !== '0) begin
            $display("FAIL rsp_idle cyc=%0d: got rsp_valid=%b expected 000", cyc, rsp_valid);
            fails++;
        end
    end

    task automatic test_reset();
        rst_n   = 1'b0;
        rr_mode = 1'b0;
        set_req(0, 1'b1, 1'b0, 19'h1, '0);
        set_req(1, 1'b1, 1'b0, 19'h2, '0);
        set_req(2, 1'b1, 1'b0, 19'h3, '0);
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b000 || ram_addr !== '0 || ram_wdata !== '0 || ram_write !== 1'b0 || rsp_rdata !== '0) begin
            $display("FAIL reset_state: got ready=%b addr=%0h wdata=%0h wr=%b rdata=%0h expected all 0",
                     req_ready, ram_addr, ram_wdata, ram_write, rsp_rdata);
            fails++;
        end
`ifdef ARB_PERF_EN
        checks++;
        if (grant_cnt !== '0) begin
            $display("FAIL reset_cnt: got %0h expected 0", grant_cnt);
            fails++;
        end
`endif
        step();
        req_valid = '0;
        rst_n     = 1'b1;
        step();
    endtask

    task automatic test_fixed();
        rr_mode = 1'b0;
        set_req(0, 1'b1, 1'b0, 19'h10, '0);
        set_req(1, 1'b1, 1'b0, 19'h20, '0);
        set_req(2, 1'b1, 1'b0, 19'h30, '0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 3'b001) begin
                $display("FAIL fixed_grant c=%0d: got %b expected 001", c, req_ready);
                fails++;
            end
            push_xfer(0);
            step();
        end
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b000) begin
            $display("FAIL idle_ready: got %b expected 000", req_ready);
            fails++;
        end
        step();
    endtask

    task automatic test_rr_burst();
        int seq [6] = '{0, 0, 1, 1, 2, 2};
        rr_mode = 1'b1;
        set_req(0, 1'b1, 1'b1, 19'h100, 19'h0AAAA);
        set_req(1, 1'b1, 1'b0, 19'h200, '0);
        set_req(2, 1'b1, 1'b0, 19'h300, '0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 3'(1 << seq[c])) begin
                $display("FAIL rr_burst c=%0d: got %b expected %b", c, req_ready, 3'(1 << seq[c]));
                fails++;
            end
            push_xfer(seq[c]);
            step();
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_single();
        set_req(1, 1'b1, 1'b1, 19'h44, 19'h7FFFF);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 3'b010) begin
                $display("FAIL rr_single c=%0d: got %b expected 010", c, req_ready);
                fails++;
            end
            push_xfer(1);
            step();
        end
        req_valid = '0;
        step();
        step();
    endtask

    task automatic test_read_latency();
        set_req(2, 1'b1, 1'b0, 19'h5, '0);
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b100) begin
            $display("FAIL lat_grant: got %b expected 100", req_ready);
            fails++;
        end
        push_xfer(2);
        step();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (ram_valid !== 1'b1 || ram_addr !== 19'h5) begin
            $display("FAIL lat_cmd: got v=%b a=%0h expected v=1 a=5", ram_valid, ram_addr);
            fails++;
        end
        step();
        step();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 3'b100 || rsp_rdata !== 19'h1ABCD) begin
            $display("FAIL lat_rsp: got id=%b data=%0h expected id=100 data=1abcd", rsp_valid, rsp_rdata);
            fails++;
        end
        step();
        set_req(2, 1'b1, 1'b1, 19'h7, 19'h12345);
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b100) begin
            $display("FAIL wr_grant: got %b expected 100", req_ready);
            fails++;
        end
        push_xfer(2);
        step();
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 3'b000) begin
                $display("FAIL wr_no_rsp c=%0d: got %b expected 000", c, rsp_valid);
                fails++;
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        rr_mode = 1'b0;
        set_req(0, 1'b1, 1'b0, 19'h40, '0);
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001) begin
            $display("FAIL b2b_grant0: got %b expected 001", req_ready);
            fails++;
        end
        push_xfer(0);
        step();
        req_valid = '0;
        set_req(1, 1'b1, 1'b0, 19'h41, '0);
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b010) begin
            $display("FAIL b2b_grant1: got %b expected 010", req_ready);
            fails++;
        end
        push_xfer(1);
        step();
        req_valid = '0;
        step();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 3'b001 || rsp_rdata !== data_of(19'h40)) begin
            $display("FAIL b2b_rsp0: got id=%b data=%0h expected id=001 data=%0h", rsp_valid, rsp_rdata, data_of(19'h40));
            fails++;
        end
        step();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 3'b010 || rsp_rdata !== data_of(19'h41)) begin
            $display("FAIL b2b_rsp1: got id=%b data=%0h expected id=010 data=%0h", rsp_valid, rsp_rdata, data_of(19'h41));
            fails++;
        end
        step();
        step();
`ifdef ARB_PERF_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            checks++;
            if (grant_cnt[i*16 +: 16] !== 16'(exp_cnt[i])) begin
                $display("FAIL grant_cnt[%0d]: got %0d expected %0d", i, grant_cnt[i*16 +: 16], exp_cnt[i]);
                fails++;
            end
        end
`endif
    endtask

    task automatic test_reset_mid();
        rr_mode = 1'b1;
        set_req(1, 1'b1, 1'b0, 19'h9, '0);
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b010) begin
            $display("FAIL mid_grant: got %b expected 010", req_ready);
            fails++;
        end
        step();
        rst_n = 1'b0;
        set_req(0, 1'b1, 1'b0, 19'h11, '0);
        set_req(1, 1'b1, 1'b0, 19'h22, '0);
        set_req(2, 1'b1, 1'b0, 19'h33, '0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 3'b000) begin
                $display("FAIL mid_rst_ready c=%0d: got %b expected 000", c, req_ready);
                fails++;
            end
            step();
        end
        for (int i = 0; i < NUM_REQ; i++) exp_cnt[i] = 0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001) begin
            $display("FAIL mid_ptr: got %b expected 001", req_ready);
            fails++;
        end
`ifdef ARB_PERF_EN
        checks++;
        if (grant_cnt !== '0) begin
            $display("FAIL mid_cnt: got %0h expected 0", grant_cnt);
            fails++;
        end
`endif
        push_xfer(0);
        step();
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001) begin
            $display("FAIL mid_burst: got %b expected 001", req_ready);
            fails++;
        end
        push_xfer(0);
        step();
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b010) begin
            $display("FAIL mid_next: got %b expected 010", req_ready);
            fails++;
        end
        push_xfer(1);
        step();
        req_valid = '0;
        repeat (5) step();
    endtask

    initial begin
        req_valid = '0;
        req_write = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            a[i]       = '0;
            d[i]       = '0;
            exp_cnt[i] = 0;
        end
        test_reset();
        test_fixed();
        test_rr_burst();
        test_single();
        test_read_latency();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
